// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle 32-bit RISC core: sequences fetch, decode, execute,
// memory and writeback steps, with a watchdog on every memory wait.
module multicycle_control #(
  parameter int unsigned Timeout = 16
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] opcode_i,
  input  logic       mem_ready_i,
  output logic       pcwrite_o,
  output logic       pcwritecond_o,
  output logic       iord_o,
  output logic       memread_o,
  output logic       memwrite_o,
  output logic       irwrite_o,
  output logic       memtoreg_o,
  output logic       regdst_o,
  output logic       regwrite_o,
  output logic       alusrca_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] pcsource_o,
  output logic [1:0] aluop_o,
  output logic       instr_done_o,
  output logic       illegal_op_o,
  output logic       bus_err_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  // Counter only has to reach Timeout-1; it saturates at all-ones beyond that.
  localparam int unsigned CntW = (Timeout > 2) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] CntLast = (Timeout == 0) ? '0 : CntW'(Timeout - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_state;
  logic            expire;

  assign mem_state = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign expire    = (Timeout != 0) && mem_state && !mem_ready_i && (cnt_q == CntLast);

  always_comb begin
    state_d       = state_q;
    pcwrite_o     = 1'b0;
    pcwritecond_o = 1'b0;
    iord_o        = 1'b0;
    memread_o     = 1'b0;
    memwrite_o    = 1'b0;
    irwrite_o     = 1'b0;
    memtoreg_o    = 1'b0;
    regdst_o      = 1'b0;
    regwrite_o    = 1'b0;
    alusrca_o     = 1'b0;
    alusrcb_o     = 2'b00;
    pcsource_o    = 2'b00;
    aluop_o       = 2'b00;
    instr_done_o  = 1'b0;
    illegal_op_o  = 1'b0;
    bus_err_o     = 1'b0;

    // Outputs stay quiet during reset so no partial writeback can escape.
    if (!reset_i) begin
      unique case (state_q)
        StFetch: begin
          memread_o = 1'b1;
          alusrcb_o = 2'b01;
          if (mem_ready_i) begin
            irwrite_o = 1'b1;
            pcwrite_o = 1'b1;
            state_d   = StDecode;
          end else if (expire) begin
            bus_err_o = 1'b1;
            state_d   = StFetch;
          end
        end
        StDecode: begin
          alusrcb_o = 2'b11;
          case (opcode_i)
            OpRtype:    state_d = StExec;
            OpLw, OpSw: state_d = StMemAdr;
            OpBeq:      state_d = StBranch;
            OpAddi:     state_d = StAddiEx;
            OpJ:        state_d = StJump;
            default: begin
              illegal_op_o = 1'b1;
              state_d      = StFetch;
            end
          endcase
        end
        StMemAdr: begin
          alusrca_o = 1'b1;
          alusrcb_o = 2'b10;
          state_d   = (opcode_i == OpLw) ? StMemRd : StMemWr;
        end
        StMemRd: begin
          memread_o = 1'b1;
          iord_o    = 1'b1;
          if (mem_ready_i) begin
            state_d = StMemWb;
          end else if (expire) begin
            bus_err_o = 1'b1;
            state_d   = StFetch;
          end
        end
        StMemWb: begin
          regwrite_o   = 1'b1;
          memtoreg_o   = 1'b1;
          instr_done_o = 1'b1;
          state_d      = StFetch;
        end
        StMemWr: begin
          memwrite_o = 1'b1;
          iord_o     = 1'b1;
          if (mem_ready_i) begin
            instr_done_o = 1'b1;
            state_d      = StFetch;
          end else if (expire) begin
            bus_err_o = 1'b1;
            state_d   = StFetch;
          end
        end
        StExec: begin
          alusrca_o = 1'b1;
          aluop_o   = 2'b10;
          state_d   = StAluWb;
        end
        StAluWb: begin
          regwrite_o   = 1'b1;
          regdst_o     = 1'b1;
          instr_done_o = 1'b1;
          state_d      = StFetch;
        end
        StBranch: begin
          alusrca_o     = 1'b1;
          aluop_o       = 2'b01;
          pcwritecond_o = 1'b1;
          pcsource_o    = 2'b01;
          instr_done_o  = 1'b1;
          state_d       = StFetch;
        end
        StAddiEx: begin
          alusrca_o = 1'b1;
          alusrcb_o = 2'b10;
          state_d   = StAddiWb;
        end
        StAddiWb: begin
          regwrite_o   = 1'b1;
          instr_done_o = 1'b1;
          state_d      = StFetch;
        end
        StJump: begin
          pcwrite_o    = 1'b1;
          pcsource_o   = 2'b10;
          instr_done_o = 1'b1;
          state_d      = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  // Any transition (including the bus-error restart of FETCH) clears the wait counter.
  always_comb begin
    cnt_d = '0;
    if (mem_state && !mem_ready_i && !expire) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StFetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = reset_i ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle stimulus and expected outputs are queued,
// then replayed and compared against a default-watchdog DUT and a Timeout=4 DUT.
module tb_multicycle_control;

  typedef logic [22:0] vec_t;
  typedef struct {
    bit         rst;
    bit         mr;
    logic [5:0] op;
    vec_t       exp;
  } ent_t;

  localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100, OpAddi = 6'b001000, OpJ = 6'b000010;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic       mem_ready = 1'b0;

  logic       a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_srca;
  logic [1:0] a_srcb, a_pcsrc, a_aluop;
  logic       a_done, a_ill, a_berr;
  logic [3:0] a_state;
  logic       b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_srca;
  logic [1:0] b_srcb, b_pcsrc, b_aluop;
  logic       b_done, b_ill, b_berr;
  logic [3:0] b_state;

  vec_t obs, obs4;
  ent_t sb[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  multicycle_control u_dut (
    .clk_i(clk), .reset_i(reset), .opcode_i(opcode), .mem_ready_i(mem_ready),
    .pcwrite_o(a_pcw), .pcwritecond_o(a_pcwc), .iord_o(a_iord), .memread_o(a_mrd),
    .memwrite_o(a_mwr), .irwrite_o(a_irw), .memtoreg_o(a_m2r), .regdst_o(a_rdst),
    .regwrite_o(a_rw), .alusrca_o(a_srca), .alusrcb_o(a_srcb), .pcsource_o(a_pcsrc),
    .aluop_o(a_aluop), .instr_done_o(a_done), .illegal_op_o(a_ill), .bus_err_o(a_berr),
    .state_o(a_state)
  );

  multicycle_control #(.Timeout(4)) u_dut4 (
    .clk_i(clk), .reset_i(reset), .opcode_i(opcode), .mem_ready_i(mem_ready),
    .pcwrite_o(b_pcw), .pcwritecond_o(b_pcwc), .iord_o(b_iord), .memread_o(b_mrd),
    .memwrite_o(b_mwr), .irwrite_o(b_irw), .memtoreg_o(b_m2r), .regdst_o(b_rdst),
    .regwrite_o(b_rw), .alusrca_o(b_srca), .alusrcb_o(b_srcb), .pcsource_o(b_pcsrc),
    .aluop_o(b_aluop), .instr_done_o(b_done), .illegal_op_o(b_ill), .bus_err_o(b_berr),
    .state_o(b_state)
  );

  assign obs  = {a_state, a_pcw, a_pcwc, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw,
                 a_srca, a_srcb, a_pcsrc, a_aluop, a_done, a_ill, a_berr};
  assign obs4 = {b_state, b_pcw, b_pcwc, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw,
                 b_srca, b_srcb, b_pcsrc, b_aluop, b_done, b_ill, b_berr};

  // Reference output table; fl means illegal_op in DECODE and watchdog expiry elsewhere.
  function automatic vec_t ev(int st, bit mr, bit fl);
    logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rdst = 0;
    logic rw = 0, srca = 0, done = 0, ill = 0, berr = 0;
    logic [1:0] srcb = 0, pcsrc = 0, aluop = 0;
    case (st)
      0:  begin mrd = 1; srcb = 2'b01; pcw = mr; irw = mr; berr = fl; end
      1:  begin srcb = 2'b11; ill = fl; end
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd = 1; iord = 1; berr = fl; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin mwr = 1; iord = 1; done = mr; berr = fl; end
      6:  begin srca = 1; aluop = 2'b10; end
      7:  begin rw = 1; rdst = 1; done = 1; end
      8:  begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; done = 1; end
      9:  begin srca = 1; srcb = 2'b10; end
      10: begin rw = 1; done = 1; end
      11: begin pcw = 1; pcsrc = 2'b10; done = 1; end
      default: ;
    endcase
    return {4'(st), pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, pcsrc, aluop,
            done, ill, berr};
  endfunction

  task automatic push(bit rst, bit mr, logic [5:0] op, int st, bit fl);
    ent_t e;
    e.rst = rst;
    e.mr  = mr;
    e.op  = op;
    e.exp = rst ? '0 : ev(st, mr, fl);
    sb.push_back(e);
  endtask

  // Queues a whole instruction; mem_ready is randomised in states that must ignore it.
  task automatic push_instr(logic [5:0] op, int waits);
    bit legal;
    legal = (op == OpR) || (op == OpLw) || (op == OpSw) || (op == OpBeq) ||
            (op == OpAddi) || (op == OpJ);
    push(0, 1, op, 0, 0);
    push(0, 1'($urandom_range(0, 1)), op, 1, !legal);
    if (op == OpR) begin
      push(0, 1'($urandom_range(0, 1)), op, 6, 0);
      push(0, 1'($urandom_range(0, 1)), op, 7, 0);
    end else if (op == OpLw || op == OpSw) begin
      push(0, 1'($urandom_range(0, 1)), op, 2, 0);
      for (int i = 0; i < waits; i++) push(0, 0, op, (op == OpLw) ? 3 : 5, 0);
      push(0, 1, op, (op == OpLw) ? 3 : 5, 0);
      if (op == OpLw) push(0, 1'($urandom_range(0, 1)), op, 4, 0);
    end else if (op == OpBeq) begin
      push(0, 1'($urandom_range(0, 1)), op, 8, 0);
    end else if (op == OpAddi) begin
      push(0, 1'($urandom_range(0, 1)), op, 9, 0);
      push(0, 1'($urandom_range(0, 1)), op, 10, 0);
    end else if (op == OpJ) begin
      push(0, 1'($urandom_range(0, 1)), op, 11, 0);
    end
  endtask

  task automatic test_reset();
    ent_t e;
    int   n = 0;
    push(1, 1, OpR, 0, 0);
    push(1, 1, OpSw, 0, 0);
    push(0, 0, OpR, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; mem_ready = e.mr; opcode = e.op;
      #1;
      checks++;
      if (obs !== e.exp) $display("FAIL reset cyc%0d: got %h want %h", n, obs, e.exp);
      else passes++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype_lw();
    ent_t e;
    int   n = 0;
    push_instr(OpR, 0);
    push_instr(OpLw, 3);
    push(0, 0, OpR, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; mem_ready = e.mr; opcode = e.op;
      #1;
      checks++;
      if (obs !== e.exp) $display("FAIL rtype_lw cyc%0d: got %h want %h", n, obs, e.exp);
      else passes++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    ent_t       e;
    int         n = 0;
    logic [5:0] ops[8];
    ops = '{OpSw, OpBeq, OpAddi, OpJ, OpR, OpLw, OpBeq, OpSw};
    for (int i = 0; i < 8; i++) push_instr(ops[i], $urandom_range(0, 2));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; mem_ready = e.mr; opcode = e.op;
      #1;
      checks++;
      if (obs !== e.exp) $display("FAIL b2b cyc%0d: got %h want %h", n, obs, e.exp);
      else passes++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    ent_t       e;
    int         n = 0;
    logic [5:0] ops[3];
    ops = '{6'b111111, 6'b000001, 6'b100000};
    for (int i = 0; i < 3; i++) push_instr(ops[i], 0);
    push_instr(OpJ, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; mem_ready = e.mr; opcode = e.op;
      #1;
      checks++;
      if (obs !== e.exp) $display("FAIL illegal cyc%0d: got %h want %h", n, obs, e.exp);
      else passes++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  // Checked against the Timeout=4 instance.
  task automatic test_timeout4();
    ent_t e;
    int   n = 0;
    push(1, 0, OpR, 0, 0);
    for (int i = 0; i < 3; i++) push(0, 0, OpR, 0, 0);
    push(0, 0, OpR, 0, 1);
    for (int i = 0; i < 3; i++) push(0, 0, OpR, 0, 0);
    push(0, 1, OpR, 0, 0);
    push(0, 0, OpR, 1, 0);
    push(0, 0, OpR, 6, 0);
    push(0, 0, OpR, 7, 0);
    push(0, 1, OpSw, 0, 0);
    push(0, 0, OpSw, 1, 0);
    push(0, 0, OpSw, 2, 0);
    for (int i = 0; i < 3; i++) push(0, 0, OpSw, 5, 0);
    push(0, 0, OpSw, 5, 1);
    push(0, 0, OpSw, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; mem_ready = e.mr; opcode = e.op;
      #1;
      checks++;
      if (obs4 !== e.exp) $display("FAIL timeout4 cyc%0d: got %h want %h", n, obs4, e.exp);
      else passes++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout16();
    ent_t e;
    int   n = 0;
    push(1, 0, OpLw, 0, 0);
    push(0, 1, OpLw, 0, 0);
    push(0, 0, OpLw, 1, 0);
    push(0, 0, OpLw, 2, 0);
    for (int i = 0; i < 15; i++) push(0, 0, OpLw, 3, 0);
    push(0, 0, OpLw, 3, 1);
    push(0, 0, OpLw, 0, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; mem_ready = e.mr; opcode = e.op;
      #1;
      checks++;
      if (obs !== e.exp) $display("FAIL timeout16 cyc%0d: got %h want %h", n, obs, e.exp);
      else passes++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    ent_t e;
    int   n = 0;
    push(1, 0, OpSw, 0, 0);
    push(0, 1, OpSw, 0, 0);
    push(0, 0, OpSw, 1, 0);
    push(0, 0, OpSw, 2, 0);
    push(0, 0, OpSw, 5, 0);
    push(1, 1, OpSw, 5, 0);
    push_instr(OpR, 0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      reset = e.rst; mem_ready = e.mr; opcode = e.op;
      #1;
      checks++;
      if (obs !== e.exp) $display("FAIL reset_mid cyc%0d: got %h want %h", n, obs, e.exp);
      else passes++;
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_rtype_lw();
    test_back_to_back();
    test_illegal();
    test_timeout4();
    test_timeout16();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
